ldm_stm_sequencer: RTL and testbench
====================================

Name: ldm_stm_sequencer

Overview:
Micro-sequencer for ARM addressing-mode-4 block transfers (LDM/STM). On start from ControlUnit it scans the 16-bit register list, computes each word address, and drives MAR_ld/MDR_ld/RF_ld/MOV/R_W, one register per memory cycle, handshaking with memory via MOC. It then optionally produces the base-register writeback value and returns control with a done pulse.

Parameters:
ADDR_W, 32, width of base and address paths
TIMEOUT, 16, MOC wait limit in cycles (used only with MOC_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising-edge
clr  in  1  synchronous active-high reset
start  in  1  one-cycle request from ControlUnit; sampled only in IDLE
P  in  1  pre(1)/post(0) index
U  in  1  up(1)/down(0)
W  in  1  base writeback enable
L  in  1  load(1)/store(0)
reg_list  in  16  register list, IR[15:0]
base  in  ADDR_W  value of Rn, sampled on start
MOC  in  1  memory operation complete
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in DONE
rf_sel  out  4  register number of current transfer
mem_addr  out  ADDR_W  address presented to MAR
MAR_ld  out  1  load MAR from mem_addr
MDR_ld  out  1  load MDR (from rf_sel register on store, from memory on load)
RF_ld  out  1  write MDR into register rf_sel
MOV  out  1  memory operation valid
R_W  out  1  1 = read, 0 = write
wb_ld  out  1  write wb_value into Rn
wb_value  out  ADDR_W  base +/- 4*N
err  out  1  MOC timeout abort (0 when feature disabled)

Behaviour:
- Reset: state IDLE; all outputs 0; internal list, count, address regs cleared. clr wins over every other input, including mid-transfer; no further strobes after the reset edge.
- N = popcount(reg_list), 0..16; 4*N computed at ADDR_W width, wraps modulo 2^ADDR_W.
- Start address: P=0,U=1 (IA) base; P=1,U=1 (IB) base+4; P=0,U=0 (DA) base-4N+4; P=1,U=0 (DB) base-4N. Registers always transferred lowest-numbered first at ascending addresses, +4 per transfer.
- wb_value = U ? base+4N : base-4N; held from SETUP until the next start.
- States: IDLE -> SETUP on start. SETUP (1 cycle): latch list, N, start address; N=0 -> DONE (no memory access, no writeback); else ADDR.
- ADDR (1 cycle): rf_sel = lowest set bit of remaining list; mem_addr = current address; MAR_ld=1; store: MDR_ld=1. -> MEM.
- MEM: MOV=1, R_W=L; load: MDR_ld=1 each cycle. Stays until MOC=1 sampled; then load -> XFER; store -> clear bit, advance address, then ADDR if bits remain, else WB/DONE.
- XFER (load only, 1 cycle): RF_ld=1, rf_sel held; clear bit, advance address; -> ADDR or WB/DONE.
- WB (only if W=1, 1 cycle): wb_ld=1. -> DONE. Load with Rn in list: WB still writes, overriding loaded value.
- DONE (1 cycle): done=1 -> IDLE.
- Minimum latency start->done: store 2N+2(+1 if W); load 3N+2(+1 if W).
- start while busy is ignored. MOC outside MEM is ignored.

Optional Feature:
MOC_TIMEOUT_EN: defined -> MEM cycle counter; if MOC is not seen within TIMEOUT cycles of MEM entry, abort to DONE with err=1 for the done cycle, skip writeback; counter reset on each MEM entry. Undefined -> MEM waits indefinitely; err tied 0; no counter logic.

Test Plan:
- STM IA, W=0, reg_list=0x000F, base=0x100, MOC=1 -> mem_addr 0x100,0x104,0x108,0x10C with rf_sel 0,1,2,3; R_W=0; no wb_ld; done 10 cycles after start.
- LDM DB, W=1, reg_list=0x8001, base=0x200 -> addrs 0x1F8 (r0), 0x1FC (r15); RF_ld twice; wb_ld with wb_value=0x1F8; done 9 cycles after start.
- LDM IB, reg_list=0x0000 -> SETUP then DONE; no MAR_ld/MOV/RF_ld/wb_ld; done 2 cycles after start.
- STM DA, reg_list=0x0010, base=0x40, MOC delayed 3 cycles -> mem_addr 0x40; MOV held 4 cycles; single transfer completes.
- clr asserted in MEM of 2nd of 4 transfers -> next cycle IDLE, all outputs 0; later start runs cleanly.
- MOC_TIMEOUT_EN, TIMEOUT=16, MOC held 0 -> abort after 16 MEM cycles, done=1 with err=1, no wb_ld.

Source files
------------

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer micro-sequencer: one register per memory cycle, then optional base writeback.
// Optional MOC_TIMEOUT_EN adds a MEM-wait watchdog that aborts with err; undefined leaves err tied low.
module ldm_stm_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              P,
  input  logic              U,
  input  logic              W,
  input  logic              L,
  input  logic [15:0]       reg_list,
  input  logic [ADDR_W-1:0] base,
  input  logic              MOC,
  output logic              busy,
  output logic              done,
  output logic [3:0]        rf_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              MAR_ld,
  output logic              MDR_ld,
  output logic              RF_ld,
  output logic              MOV,
  output logic              R_W,
  output logic              wb_ld,
  output logic [ADDR_W-1:0] wb_value,
  output logic              err,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {IDLE, SETUP, ADDR, MEM, XFER, WB, DONE} state_t;

  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  state_t              state;
  logic [15:0]         list_q;
  logic [ADDR_W-1:0]   cur_addr;
  logic                is_load;
  logic                wb_en;

  logic [ADDR_W-1:0]   four_n;
  logic [ADDR_W-1:0]   start_addr;
  logic [ADDR_W-1:0]   addr_next;
  logic [15:0]         list_next;
  logic                step;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  always_comb begin
    four_n = {{(ADDR_W-5){1'b0}}, popcount16(reg_list)} << 2;
    case ({P, U})
      2'b01:   start_addr = base;
      2'b11:   start_addr = base + WORD_STEP;
      2'b00:   start_addr = base - four_n + WORD_STEP;
      default: start_addr = base - four_n;
    endcase
    list_next = list_q & ~(16'h0001 << rf_sel);
    addr_next = cur_addr + WORD_STEP;
    // A transfer retires on MOC for a store, or after the register-file write for a load.
    step      = (state == MEM && MOC && !is_load) || (state == XFER);
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

`ifdef MOC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;
`else
  localparam int timeout_unused = TIMEOUT;
  assign err = 1'b0;
`endif

  // Memory handshake: MOV stays high with a stable address/data path until MOC is sampled high in MEM.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      list_q   <= '0;
      cur_addr <= '0;
      is_load  <= 1'b0;
      wb_en    <= 1'b0;
      rf_sel   <= '0;
      mem_addr <= '0;
      wb_value <= '0;
      done     <= 1'b0;
      MAR_ld   <= 1'b0;
      MDR_ld   <= 1'b0;
      RF_ld    <= 1'b0;
      MOV      <= 1'b0;
      R_W      <= 1'b0;
      wb_ld    <= 1'b0;
`ifdef MOC_TIMEOUT_EN
      to_cnt   <= '0;
      err      <= 1'b0;
`endif
    end else begin
      done   <= 1'b0;
      MAR_ld <= 1'b0;
      MDR_ld <= 1'b0;
      RF_ld  <= 1'b0;
      MOV    <= 1'b0;
      R_W    <= 1'b0;
      wb_ld  <= 1'b0;
`ifdef MOC_TIMEOUT_EN
      err    <= 1'b0;
`endif
      case (state)
        IDLE: if (start) begin
          list_q   <= reg_list;
          cur_addr <= start_addr;
          wb_value <= U ? base + four_n : base - four_n;
          is_load  <= L;
          wb_en    <= W;
          state    <= SETUP;
        end
        SETUP: if (list_q == 16'h0) begin
          state <= DONE;
          done  <= 1'b1;
        end else begin
          state    <= ADDR;
          rf_sel   <= lowest_set(list_q);
          mem_addr <= cur_addr;
          MAR_ld   <= 1'b1;
          MDR_ld   <= ~is_load;
        end
        ADDR: begin
          state  <= MEM;
          MOV    <= 1'b1;
          R_W    <= is_load;
          MDR_ld <= is_load;
`ifdef MOC_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        MEM: if (MOC) begin
          if (is_load) begin
            state <= XFER;
            RF_ld <= 1'b1;
          end
        end else begin
`ifdef MOC_TIMEOUT_EN
          if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
            MOV    <= 1'b1;
            R_W    <= is_load;
            MDR_ld <= is_load;
          end
`else
          MOV    <= 1'b1;
          R_W    <= is_load;
          MDR_ld <= is_load;
`endif
        end
        XFER: begin
        end
        WB: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (step) begin
        list_q   <= list_next;
        cur_addr <= addr_next;
        if (list_next != 16'h0) begin
          state    <= ADDR;
          rf_sel   <= lowest_set(list_next);
          mem_addr <= addr_next;
          MAR_ld   <= 1'b1;
          MDR_ld   <= ~is_load;
        end else if (wb_en) begin
          state <= WB;
          wb_ld <= 1'b1;
        end else begin
          state <= DONE;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: transaction-level model predicts address/register/writeback streams and latency.
// Define MOC_TIMEOUT_EN on both files to also exercise the MOC watchdog abort.
module tb_ldm_stm_sequencer;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              clr, start, P, U, W, L, MOC;
  logic [15:0]       reg_list;
  logic [ADDR_W-1:0] base;
  logic              busy, done, MAR_ld, MDR_ld, RF_ld, MOV, R_W, wb_ld, err;
  logic [3:0]        rf_sel;
  logic [ADDR_W-1:0] mem_addr, wb_value;
  logic [2:0]        state_dbg;

  ldm_stm_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clr(clr), .start(start), .P(P), .U(U), .W(W), .L(L),
    .reg_list(reg_list), .base(base), .MOC(MOC),
    .busy(busy), .done(done), .rf_sel(rf_sel), .mem_addr(mem_addr),
    .MAR_ld(MAR_ld), .MDR_ld(MDR_ld), .RF_ld(RF_ld), .MOV(MOV), .R_W(R_W),
    .wb_ld(wb_ld), .wb_value(wb_value), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int exp_lat = 0;
  int exp_mov_len = 1;
  int moc_delay = 0;
  int moc_run = 0;
  int mov_run = 0;
  bit moc_always = 0;
  bit active = 0;
  bit chk_en = 0;
  bit exp_load = 0;
  bit exp_err = 0;
  bit done_seen = 0;
  logic [ADDR_W-1:0] exp_wb_val;
  logic [ADDR_W-1:0] last_start, last_wb;
  int last_lat;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [3:0]        exp_rf_q[$];
  logic [3:0]        exp_ld_q[$];
  logic [ADDR_W-1:0] exp_wb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: raises MOC after MOV has been seen for moc_delay+1 cycles.
  always @(negedge clk) begin
    if (MOV === 1'b1) moc_run++;
    else moc_run = 0;
    MOC = moc_always || ((MOV === 1'b1) && moc_delay >= 0 && moc_run > moc_delay);
  end

  // Compare process: mid-cycle sampling of every registered output.
  always @(posedge clk) begin
    cyc++;
    #3;
    if (chk_en) begin
      check("busy", busy, active && cyc > start_cyc && cyc <= start_cyc + exp_lat);
      check("err", err, active && exp_err && cyc == start_cyc + exp_lat);
      if (MAR_ld) begin
        if (exp_addr_q.size() == 0) check("mar_ld_unexpected", MAR_ld, 0);
        else begin
          check("mem_addr", mem_addr, exp_addr_q.pop_front());
          check("mar_rf_sel", rf_sel, exp_rf_q.pop_front());
          check("mar_mdr_ld", MDR_ld, !exp_load);
        end
      end
      if (MOV) begin
        check("r_w", R_W, exp_load);
        check("mov_mdr_ld", MDR_ld, exp_load);
        mov_run++;
      end else begin
        if (mov_run > 0 && active) check("mov_len", mov_run, exp_mov_len);
        mov_run = 0;
      end
      if (RF_ld) begin
        if (exp_ld_q.size() == 0) check("rf_ld_unexpected", RF_ld, 0);
        else check("rf_ld_sel", rf_sel, exp_ld_q.pop_front());
      end
      if (wb_ld) begin
        if (exp_wb_q.size() == 0) check("wb_ld_unexpected", wb_ld, 0);
        else check("wb_value", wb_value, exp_wb_q.pop_front());
      end
      if (done) begin
        if (!active) check("done_unexpected", done, 0);
        else begin
          check("latency", cyc - start_cyc, exp_lat);
          check("wb_value_hold", wb_value, exp_wb_val);
          done_seen = 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // d = MOC delay in MEM cycles; d < 0 means MOC never arrives (watchdog builds only).
  task automatic begin_txn(input bit p, input bit u, input bit w, input bit l,
                           input logic [15:0] lst, input logic [ADDR_W-1:0] b,
                           input int d, input bit hi);
    int n;
    int k;
    bit to;
    logic [ADDR_W-1:0] four_n;
    logic [ADDR_W-1:0] a;
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 16; i++) if (lst[i]) n++;
    four_n = ADDR_W'(4 * n);
    case ({p, u})
      2'b01:   a = b;
      2'b11:   a = b + 4;
      2'b00:   a = b - four_n + 4;
      default: a = b - four_n;
    endcase
    last_start = a;
    to = (d < 0);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (lst[i]) begin
        if (!to || k == 0) begin
          exp_addr_q.push_back(a);
          exp_rf_q.push_back(4'(i));
        end
        if (l && !to) exp_ld_q.push_back(4'(i));
        a = a + 4;
        k++;
      end
    end
    exp_wb_val = u ? b + four_n : b - four_n;
    last_wb = exp_wb_val;
    if (w && n > 0 && !to) exp_wb_q.push_back(exp_wb_val);
    if (to) exp_lat = TIMEOUT + 3;
    else if (n == 0) exp_lat = 2;
    else exp_lat = 2 + n * (d + (l ? 3 : 2)) + (w ? 1 : 0);
    last_lat = exp_lat;
    exp_err = to && n > 0;
    exp_load = l;
    exp_mov_len = to ? TIMEOUT : d + 1;
    moc_delay = d;
    moc_always = hi;
    P = p; U = u; W = w; L = l; reg_list = lst; base = b;
    start = 1'b1;
    start_cyc = cyc;
    done_seen = 0;
    active = 1;
    @(negedge clk);
    start = 1'b0;
    P = ~p; U = ~u; W = ~w; L = ~l; reg_list = ~lst; base = ~b;
  endtask

  // glitch > 0 pulses a bogus start at that cycle offset, which must be ignored.
  task automatic finish_txn(input int glitch);
    for (int k = 0; k < exp_lat + 4; k++) begin
      @(negedge clk);
      if (glitch > 0 && cyc == start_cyc + glitch) begin
        start = 1'b1;
        reg_list = 16'hFFFF;
      end else start = 1'b0;
    end
    start = 1'b0;
    check("done_seen", done_seen, 1);
    check("addr_q_empty", exp_addr_q.size(), 0);
    check("ld_q_empty", exp_ld_q.size(), 0);
    check("wb_q_empty", exp_wb_q.size(), 0);
    active = 0;
    moc_always = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"}, {busy, done, MAR_ld, MDR_ld, RF_ld, MOV, R_W, wb_ld, err}, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_rf_sel"}, rf_sel, 0);
    check({tag, "_wb_value"}, wb_value, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clr = 1'b1; start = 1'b0; P = 0; U = 0; W = 0; L = 0;
    reg_list = '0; base = '0;
    repeat (2) @(posedge clk);
    #3;
    check_all_zero("reset");
    chk_en = 1;
    @(negedge clk);
    clr = 1'b0;

    // STM IA, MOC held high throughout
    begin_txn(0, 1, 0, 0, 16'h000F, 32'h100, 0, 1);
    finish_txn(0);
    check("pin_ia_lat", last_lat, 10);
    check("pin_ia_start", last_start, 32'h100);

    // LDM DB with writeback
    begin_txn(1, 0, 1, 1, 16'h8001, 32'h200, 0, 0);
    finish_txn(0);
    check("pin_db_start", last_start, 32'h1F8);
    check("pin_db_wb", last_wb, 32'h1F8);
    check("pin_db_lat", last_lat, 9);

    // empty list
    begin_txn(1, 1, 1, 1, 16'h0000, 32'h300, 0, 0);
    finish_txn(0);
    check("pin_empty_lat", last_lat, 2);

    // STM DA, slow memory, start pulse during DONE ignored
    begin_txn(0, 0, 0, 0, 16'h0010, 32'h40, 3, 0);
    finish_txn(7);
    check("pin_da_start", last_start, 32'h40);
    check("pin_da_lat", last_lat, 7);

    // clr during MEM of the second transfer
    begin_txn(0, 1, 0, 0, 16'h00F0, 32'h1000, 2, 0);
    for (int k = 0; k < 20 && cyc < start_cyc + 7; k++) @(negedge clk);
    check("clr_in_mem", MOV, 1);
    clr = 1'b1;
    active = 0;
    exp_addr_q.delete(); exp_rf_q.delete(); exp_ld_q.delete(); exp_wb_q.delete();
    @(posedge clk);
    #3;
    check_all_zero("clr");
    @(negedge clk);
    clr = 1'b0;
    moc_always = 0;

    // LDM IA after clr, start pulse mid-run ignored
    begin_txn(0, 1, 1, 1, 16'hA5A5, 32'h2000, 1, 0);
    finish_txn(5);
    check("pin_ia8_lat", last_lat, 35);

    // STM IB full list with address wrap
    begin_txn(1, 1, 1, 0, 16'hFFFF, 32'hFFFF_FFF0, 0, 0);
    finish_txn(0);
    check("pin_ib_start", last_start, 32'hFFFF_FFF4);
    check("pin_ib_wb", last_wb, 32'h30);

    // LDM DA with writeback
    begin_txn(0, 0, 1, 1, 16'h0421, 32'h10, 0, 0);
    finish_txn(0);
    check("pin_lda_start", last_start, 32'h8);
    check("pin_lda_wb", last_wb, 32'h4);
    check("pin_lda_lat", last_lat, 12);

    // STM DB, slow memory
    begin_txn(1, 0, 0, 0, 16'h1248, 32'h80, 2, 0);
    finish_txn(0);
    check("pin_db_store_start", last_start, 32'h70);

`ifdef MOC_TIMEOUT_EN
    // MOC never arrives: abort with err, no writeback
    begin_txn(0, 1, 1, 0, 16'h0003, 32'h500, -1, 0);
    finish_txn(0);
    check("pin_to_lat", last_lat, TIMEOUT + 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
